// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first) run on unsigned magnitudes, signs fixed at the end.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   opa;      // multiplicand, or dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   opb;      // multiplier shifting right, or divisor
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic               is_div;
    logic               neg_p;    // product or quotient sign
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               is_md;
    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_md     = ~op[2];
        sgn       = ~op[0];
        abs_a     = (sgn && a[WIDTH-1]) ? -a : a;
        abs_b     = (sgn && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
        div_shift = {rem[WIDTH-1:0], opa[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        prod_fix  = neg_p ? -acc : acc;
        // The restoring loop already leaves |a| as remainder when b=0; only the quotient needs forcing.
        quot_fix  = div_zero ? {WIDTH{1'b1}} : (neg_p ? -opa : opa);
        rem_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            rem      <= '0;
            is_div   <= 1'b0;
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && is_md) begin
                        opa      <= abs_a;
                        opb      <= abs_b;
                        acc      <= '0;
                        rem      <= '0;
                        count    <= '0;
                        is_div   <= op[1];
                        neg_p    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= sgn & a[WIDTH-1];
                        div_zero <= op[1] & (b == '0);
                        state    <= S_CALC;
                    end else if (start && op == 3'b100) begin
                        hi_q <= a;
                    end else if (start && op == 3'b101) begin
                        lo_q <= a;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        rem <= div_ge ? (div_shift - {1'b0, opb}) : div_shift;
                        opa <= {opa[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        opb <= {1'b0, opb[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        lo_q <= quot_fix;
                        hi_q <= rem_fix;
                    end else begin
                        lo_q <= prod_fix[WIDTH-1:0];
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the multicycle CPU's execute step. It takes the same A/B operand registers that drive the ALU and owns the architectural HI/LO registers. The control FSM stalls on busy, and MFHI/MFLO values are taken from its hi/lo outputs into the ALUOut mux.
Supports MULT, MULTU, DIV, DIVU (32 iteration cycles) and MTHI/MTLO (single-cycle writes).

Parameters:
WIDTH, 32, operand and HI/LO width
ITER, 32, iteration count; must equal WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
a  input  WIDTH  operand A (rs); multiplicand/dividend; MTHI/MTLO source
b  input  WIDTH  operand B (rt); multiplier/divisor
busy  output  1  operation in progress; new start ignored
done  output  1  one-cycle pulse when HI/LO updated by mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators cleared. Reset takes effect at the next edge regardless of state, including mid-operation. An aborted op leaves HI/LO=0 and no done pulse.
- States: IDLE, CALC, FIX.
- IDLE, accept edge E0 (start=1):
  - MULT/MULTU/DIV/DIVU: latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Latch the sign flags: product sign = a[31]^b[31], quotient sign = a[31]^b[31], remainder sign = a[31]. Signs are forced to 0 for unsigned ops.
  - Clear the 64-bit accumulator and counter, go to CALC. busy=1 from the cycle after E0.
- MTHI/MTLO at E0: hi<=a or lo<=a on that edge. Stay IDLE, busy stays 0, no done.
- op 110/111 with start=1: ignored.
- CALC: one iteration per edge; counter increments each edge. After the 32nd CALC edge (E32) go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits so no carry is lost.
- FIX edge E33:
  - Apply the sign correction (two's-complement negate where the flag is set).
  - Write the result: mul gives hi=product[63:32], lo=product[31:0]; div gives lo=quotient, hi=remainder.
  - done=1 in the cycle after E33 only; busy=0 from that cycle; go to IDLE.
- Latency and throughput:
  - busy is high for exactly 33 cycles.
  - A new start may be accepted in the same cycle done=1 (back-to-back).
  - hi/lo hold their old values throughout CALC.
- Divide by zero:
  - lo=32'hFFFFFFFF, hi=a (original dividend, unsigned and signed alike).
  - Full 33-cycle latency, done pulses normally.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0.
- start while busy: ignored; a and b may change freely during CALC.
- Remainder sign follows the dividend. Quotient truncates toward zero.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high 33 cycles; done one cycle; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then issue DIVU a=100, b=7 in the done cycle -> accepted; lo=14, hi=2 after 33 more cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV/DIVU b=0, a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678, done after 33 cycles.
- MTHI a=0xCAFEF00D, then MTLO a=0x0BADBEEF -> hi/lo updated the edge after each start; busy and done stay 0. MTHI with start=1 during a MULT -> ignored, MULT result unchanged.
- Start MULT 5*6, assert rst at CALC cycle 10 for one cycle -> busy=0, hi=lo=0, no done. Then MULTU 5*6 -> lo=30, hi=0.
